qspi_pad_arb: RTL and testbench

- Arbitrates one shared QSPI pad bundle (sclk, csn, dat[3:0]) between NUM_REQ on-chip QSPI masters, e.g. the custom QSPI controller and the SPI flash controller.
- Round-robin grant on a held-request handshake.
- After each release, a guard interval with the bus parked idle.
- Optional watchdog that revokes a master holding the bus too long.
- Sits in the SoC top, between the masters and the pad instances.

---
 rtl/qspi_pad_arb_pkg.sv | 19 +
 rtl/qspi_pad_arb_if.sv | 27 ++
 rtl/qspi_pad_arb_rr_arbiter.sv | 45 ++++
 rtl/qspi_pad_arb.sv | 167 ++++++++++++++++
 tb/tb_qspi_pad_arb.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_pad_arb_pkg.sv
// Shared types and constants for the QSPI pad arbiter: FSM states, the parked
// (idle) pad levels and counter widths.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GUARD
  } state_t;

  localparam logic       SCLK_IDLE = 1'b0;
  localparam logic       CSN_IDLE  = 1'b1;
  localparam logic [3:0] SDO_IDLE  = 4'h0;
  localparam logic [3:0] OE_IDLE   = 4'h0;

  localparam int GUARD_W  = 4;
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/qspi_pad_arb_if.sv
// Master-side bundle of the QSPI pad arbiter: request/grant handshake plus
// every master's pad-facing signals and the returned serial data.
interface qspi_pad_arb_if #(
  parameter int NUM_REQ = 2
);
  // Handshake: a master raises req_i[k] and holds it for its whole transaction;
  // gnt_o[k] (registered, at most one bit set) stays high until req_i[k] drops
  // or the watchdog revokes; only the granted master reaches the pads.
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic [NUM_REQ-1:0]   req_sclk_i;
  logic [NUM_REQ-1:0]   req_csn_i;
  logic [4*NUM_REQ-1:0] req_sdo_i;
  logic [4*NUM_REQ-1:0] req_oe_i;
  logic [4*NUM_REQ-1:0] req_sdi_o;

  modport slave (
    input  req_i, req_sclk_i, req_csn_i, req_sdo_i, req_oe_i,
    output gnt_o, req_sdi_o
  );

  modport master (
    output req_i, req_sclk_i, req_csn_i, req_sdo_i, req_oe_i,
    input  gnt_o, req_sdi_o
  );

endinterface

// File: rtl/qspi_pad_arb_rr_arbiter.sv
// Combinational round-robin search: first set bit of i_elig at or after i_ptr,
// wrapping modulo N. Returns valid, one-hot winner and winner index.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         i_elig,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [N-1:0]         o_onehot,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [IW1-1:0] w_sum;

  // Rotating a doubled copy puts the pointer position at bit 0.
  assign w_dbl   = {i_elig, i_elig};
  assign w_shift = w_dbl >> i_ptr;
  assign w_rot   = w_shift[N-1:0];

  always_comb begin
    o_valid = 1'b0;
    w_sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_ptr} + IW1'(i);
      end
    end
  end

  assign o_idx = (w_sum >= IW1'(N)) ? IW'(w_sum - IW1'(N)) : w_sum[IW-1:0];

  always_comb begin
    o_onehot = '0;
    for (int j = 0; j < N; j++) begin
      o_onehot[j] = o_valid && (o_idx == IW'(j));
    end
  end

endmodule

// File: rtl/qspi_pad_arb.sv
// Round-robin arbiter sharing one QSPI pad bundle between NUM_REQ masters, with a
// parked-idle guard after each release. QSPI_ARB_TIMEOUT_EN adds the ownership watchdog.
module qspi_pad_arb
  import qspi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int GUARD_CYC   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  qspi_pad_arb_if.slave              m_if,
  output logic                       pad_sclk_o,
  output logic                       pad_csn_o,
  output logic [3:0]                 pad_sdo_o,
  output logic [3:0]                 pad_oe_o,
  input  logic [3:0]                 pad_sdi_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       timeout_o,
  output state_t                     dbg_state_o
);
  localparam int OW  = $clog2(NUM_REQ);
  localparam int OW1 = OW + 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYC - 1);
  localparam state_t REL_STATE = (GUARD_CYC > 0) ? GUARD : IDLE;

  state_t               r_state, w_state_n;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_n;
  logic [NUM_REQ-1:0]   r_mask, w_mask_n;
  logic [OW-1:0]        r_owner, w_owner_n;
  logic [OW-1:0]        r_ptr, w_ptr_n;
  logic [GUARD_W-1:0]   r_guard, w_guard_n;
  logic [NUM_REQ-1:0]   w_elig, w_win_oh;
  logic [OW-1:0]        w_win_idx, w_ptr_inc;
  logic [OW1-1:0]       w_ptr_sum;
  logic                 w_win_vld, w_own_req;

  assign w_elig = m_if.req_i & ~r_mask;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_valid (w_win_vld),
    .o_onehot(w_win_oh),
    .o_idx   (w_win_idx)
  );

  assign w_ptr_sum = {1'b0, w_win_idx} + OW1'(1);
  assign w_ptr_inc = (w_ptr_sum == OW1'(NUM_REQ)) ? '0 : w_ptr_sum[OW-1:0];

  always_comb begin
    w_own_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == OW'(k)) w_own_req = m_if.req_i[k];
    end
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt;
  logic                r_timeout, w_timeout_n, w_to_hit;

  assign w_to_hit = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));

  // Cleared outside GRANT so it reads zero on the first owned cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= (r_state == GRANT) ? r_to_cnt + TO_CNT_W'(1) : '0;
      r_timeout <= w_timeout_n;
    end
  end

  assign timeout_o = r_timeout;
`else
  // TIMEOUT_CYC has no effect in this build; the expression is constant zero.
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_guard_n = r_guard;
    w_mask_n  = r_mask & m_if.req_i;
`ifdef QSPI_ARB_TIMEOUT_EN
    w_timeout_n = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_n = GRANT;
          w_gnt_n   = w_win_oh;
          w_owner_n = w_win_idx;
          w_ptr_n   = w_ptr_inc;
        end
      end
      GRANT: begin
        if (!w_own_req) begin
          w_state_n = REL_STATE;
          w_gnt_n   = '0;
          w_guard_n = '0;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        else if (w_to_hit) begin
          w_state_n          = REL_STATE;
          w_gnt_n            = '0;
          w_guard_n          = '0;
          w_timeout_n        = 1'b1;
          w_mask_n[r_owner]  = 1'b1;
        end
`endif
      end
      GUARD: begin
        if (r_guard == GUARD_LAST) w_state_n = IDLE;
        else                       w_guard_n = r_guard + GUARD_W'(1);
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_mask  <= '0;
      r_guard <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt   <= w_gnt_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_mask  <= w_mask_n;
      r_guard <= w_guard_n;
    end
  end

  always_comb begin
    pad_sclk_o     = SCLK_IDLE;
    pad_csn_o      = CSN_IDLE;
    pad_sdo_o      = SDO_IDLE;
    pad_oe_o       = OE_IDLE;
    m_if.req_sdi_o = '0;
    if (r_state == GRANT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (r_owner == OW'(k)) begin
          pad_sclk_o               = m_if.req_sclk_i[k];
          pad_csn_o                = m_if.req_csn_i[k];
          pad_sdo_o                = m_if.req_sdo_i[4*k +: 4];
          pad_oe_o                 = m_if.req_oe_i[4*k +: 4];
          m_if.req_sdi_o[4*k +: 4] = pad_sdi_i;
        end
      end
    end
  end

  assign m_if.gnt_o  = r_gnt;
  assign busy_o      = (r_state != IDLE);
  assign owner_o     = r_owner;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_qspi_pad_arb.sv
// Bench for qspi_pad_arb: two instances (guard 2 and guard 0) share one stimulus
// stream; a timestamp-based reference model feeds a grant scoreboard and pad checks.
module tb_qspi_pad_arb;
  import qspi_arb_pkg::*;

  localparam int NUM_REQ     = 2;
  localparam int DW          = 4 * NUM_REQ;
  localparam int OW          = $clog2(NUM_REQ);
  localparam int G0          = 2;
  localparam int G1          = 0;
  localparam int TIMEOUT_CYC = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [NUM_REQ-1:0] r_req, r_sclk, r_csn;
  logic [DW-1:0]      r_sdo, r_oe;
  logic [3:0]         r_pad_sdi;

  qspi_pad_arb_if #(.NUM_REQ(NUM_REQ)) if0 ();
  qspi_pad_arb_if #(.NUM_REQ(NUM_REQ)) if1 ();

  assign if0.req_i = r_req;  assign if1.req_i = r_req;
  assign if0.req_sclk_i = r_sclk;  assign if1.req_sclk_i = r_sclk;
  assign if0.req_csn_i = r_csn;  assign if1.req_csn_i = r_csn;
  assign if0.req_sdo_i = r_sdo;  assign if1.req_sdo_i = r_sdo;
  assign if0.req_oe_i = r_oe;  assign if1.req_oe_i = r_oe;

  logic          sclk0, csn0, busy0, to0, sclk1, csn1, busy1, to1;
  logic [3:0]    sdo0, oe0, sdo1, oe1;
  logic [OW-1:0] owner0, owner1;
  state_t        state0, state1;

  qspi_pad_arb #(.NUM_REQ(NUM_REQ), .GUARD_CYC(G0), .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .m_if(if0.slave),
    .pad_sclk_o(sclk0), .pad_csn_o(csn0), .pad_sdo_o(sdo0), .pad_oe_o(oe0),
    .pad_sdi_i(r_pad_sdi), .busy_o(busy0), .owner_o(owner0), .timeout_o(to0),
    .dbg_state_o(state0)
  );

  qspi_pad_arb #(.NUM_REQ(NUM_REQ), .GUARD_CYC(G1), .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .m_if(if1.slave),
    .pad_sclk_o(sclk1), .pad_csn_o(csn1), .pad_sdo_o(sdo1), .pad_oe_o(oe1),
    .pad_sdi_i(r_pad_sdi), .busy_o(busy1), .owner_o(owner1), .timeout_o(to1),
    .dbg_state_o(state1)
  );

  // ---------------- reference model ----------------
  int                 cyc;
  int                 m_owner[2], m_free[2], m_ptr[2], m_gstart[2], m_last[2];
  logic               m_to[2];
  logic [NUM_REQ-1:0] m_mask[2];
  logic [31:0]        exp_q0[$];
  logic [31:0]        exp_q1[$];
  logic [NUM_REQ-1:0] prev_gnt[2];
  int                 tests, fails;
  int                 hold_left[NUM_REQ];

  function automatic int guard_of(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  // Ownership is tracked as timestamps: who owns since which edge, and the
  // first edge at which the bus may be handed out again.
  task automatic model_step();
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_owner[d] = -1;  m_free[d] = cyc + 1;  m_ptr[d] = 0;
        m_last[d]  = 0;   m_to[d]   = 1'b0;     m_mask[d] = '0;
      end else begin
        logic [NUM_REQ-1:0] old_mask;
        logic [31:0]        ent;
        int                 rev, win, c;
        old_mask = m_mask[d];
        rev = -1;
        win = -1;
        m_to[d] = 1'b0;
        if (m_owner[d] >= 0) begin
          if (!r_req[m_owner[d]]) begin
            m_owner[d] = -1;
            m_free[d]  = cyc + 1 + guard_of(d);
          end
`ifdef QSPI_ARB_TIMEOUT_EN
          else if (cyc - m_gstart[d] == TIMEOUT_CYC) begin
            rev        = m_owner[d];
            m_to[d]    = 1'b1;
            m_owner[d] = -1;
            m_free[d]  = cyc + 1 + guard_of(d);
          end
`endif
        end else if (cyc >= m_free[d]) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            c = (m_ptr[d] + i) % NUM_REQ;
            if (win < 0 && r_req[c] && !old_mask[c]) win = c;
          end
          if (win >= 0) begin
            m_owner[d] = win;  m_last[d] = win;  m_gstart[d] = cyc;
            m_ptr[d]   = (win + 1) % NUM_REQ;
            ent = {cyc[23:0], 8'(win)};
            if (d == 0) exp_q0.push_back(ent);
            else        exp_q1.push_back(ent);
          end
        end
        m_mask[d] = old_mask & r_req;
        if (rev >= 0) m_mask[d][rev] = 1'b1;
      end
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle=%0d actual=%0h expected=%0h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return 255;
  endfunction

  task automatic mon_inst(input int d, input logic [NUM_REQ-1:0] gnt, input logic [DW-1:0] sdi,
                          input logic sclk, input logic csn, input logic [3:0] sdo,
                          input logic [3:0] oe, input logic busy, input logic [OW-1:0] owner,
                          input logic to);
    logic [31:0]        act, e;
    logic [NUM_REQ-1:0] eg;
    int                 o, qn;
    o = m_owner[d];
    if (gnt != prev_gnt[d] && gnt != '0) begin
      act = {cyc[23:0], 8'(onehot_idx(gnt))};
      qn  = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (qn == 0) begin
        tests++;
        fails++;
        $display("FAIL grant_unexpected dut%0d cycle=%0d actual=%0h expected=none", d, cyc, act);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        check("grant_evt", d, act, e);
      end
    end
    prev_gnt[d] = gnt;
    eg = (o >= 0) ? (NUM_REQ'(1) << o) : '0;
    check("gnt", d, 32'(gnt), 32'(eg));
    check("owner", d, 32'(owner), 32'(m_last[d]));
    check("busy", d, 32'(busy), 32'((o >= 0) || (cyc < m_free[d] - 1)));
    check("timeout", d, 32'(to), 32'(m_to[d]));
    if (o >= 0) begin
      check("pad_sclk", d, 32'(sclk), 32'(r_sclk[o]));
      check("pad_csn", d, 32'(csn), 32'(r_csn[o]));
      check("pad_sdo", d, 32'(sdo), 32'(r_sdo[4*o +: 4]));
      check("pad_oe", d, 32'(oe), 32'(r_oe[4*o +: 4]));
      check("req_sdi", d, 32'(sdi), 32'(DW'(r_pad_sdi) << (4 * o)));
    end else begin
      check("pad_sclk", d, 32'(sclk), 32'(0));
      check("pad_csn", d, 32'(csn), 32'(1));
      check("pad_sdo", d, 32'(sdo), 32'(0));
      check("pad_oe", d, 32'(oe), 32'(0));
      check("req_sdi", d, 32'(sdi), 32'(0));
    end
  endtask

  initial begin
    prev_gnt[0] = '0;
    prev_gnt[1] = '0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        mon_inst(0, if0.gnt_o, if0.req_sdi_o, sclk0, csn0, sdo0, oe0, busy0, owner0, to0);
        mon_inst(1, if1.gnt_o, if1.req_sdi_o, sclk1, csn1, sdo1, oe1, busy1, owner1, to1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_data();
    r_sclk    = NUM_REQ'($urandom);
    r_csn     = NUM_REQ'($urandom);
    r_sdo     = DW'($urandom);
    r_oe      = DW'($urandom);
    r_pad_sdi = 4'($urandom);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
    rand_data();
  endtask

  // Each master raises req with p_raise %, holds it for hmin..hmax granted
  // cycles, and may abandon an ungranted request with p_ab %.
  task automatic run_random(input int n, input int p_raise, input int hmin, input int hmax,
                            input int p_ab);
    repeat (n) begin
      tick();
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!r_req[k]) begin
          if ($urandom_range(99) < p_raise) begin
            r_req[k]     = 1'b1;
            hold_left[k] = $urandom_range(hmax, hmin);
          end
        end else if (if0.gnt_o[k]) begin
          if (hold_left[k] <= 1) r_req[k] = 1'b0;
          else                   hold_left[k]--;
        end else if ($urandom_range(99) < p_ab) begin
          r_req[k] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    r_req = '0;
    rand_data();
    repeat (3) tick();
    rst = 1'b0;

    // single master, fixed pad data in
    r_req = 2'b01;
    repeat (5) begin
      tick();
      r_pad_sdi = 4'hA;
    end
    r_req = 2'b00;
    repeat (5) tick();

    // both masters keep coming back with 3-cycle transactions
    run_random(60, 100, 3, 3, 0);
    r_req = 2'b00;
    repeat (6) tick();

    // master 1 arrives while master 0 owns
    r_req = 2'b01;  repeat (2) tick();
    r_req = 2'b11;  repeat (4) tick();
    r_req = 2'b10;  repeat (8) tick();
    r_req = 2'b00;  repeat (5) tick();

    // master 1 pulses during master 0 ownership
    r_req = 2'b01;  repeat (2) tick();
    r_req = 2'b11;  tick();
    r_req = 2'b01;  repeat (3) tick();
    r_req = 2'b00;  repeat (6) tick();

`ifdef QSPI_ARB_TIMEOUT_EN
    // master 0 overstays, then must drop req before it is served again
    r_req = 2'b01;  repeat (TIMEOUT_CYC + 12) tick();
    r_req = 2'b00;  tick();
    r_req = 2'b01;  repeat (6) tick();
    r_req = 2'b00;  repeat (5) tick();
`endif

    // reset in the middle of an ownership
    r_req = 2'b10;  repeat (3) tick();
    rst = 1'b1;     tick();
    rst = 1'b0;
    r_req = 2'b00;  repeat (4) tick();

    run_random(2500, 30, 1, 6, 10);
    r_req = 2'b00;
    repeat (20) tick();

    check("leftover_q", 0, 32'(exp_q0.size()), 32'(0));
    check("leftover_q", 1, 32'(exp_q1.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
